// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception/interrupt sequencer:
// vectors, FSM encodings and cause codes.
package exc_ctrl_pkg;

   localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
   localparam logic [31:0] RESET_PC   = 32'h0000_3000;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_TRAP  = 2'd1;
   localparam logic [1:0] ST_RET   = 2'd2;
   localparam logic [1:0] ST_GUARD = 2'd3;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/exc_ctrl_if.sv
// Signal bundle between exc_ctrl and the M stage, CP0,
// fetch and the interrupting devices.
interface exc_ctrl_if #(
   parameter int NUM_INT = 6
);

   logic [NUM_INT-1:0] hw_irq;
   logic [NUM_INT-1:0] irq_ack;
   logic               m_valid;
   logic [31:0]        m_pc;
   logic               m_bd;
   logic [4:0]         m_exc_code;
   logic               m_eret;
   logic               cp0_req;
   logic [31:0]        cp0_epc;
   logic [NUM_INT-1:0] cp0_hwint;
   logic               cp0_is_exc;
   logic [4:0]         cp0_exc_code;
   logic [31:0]        cp0_pc;
   logic               cp0_isbd;
   logic               cp0_exl_clear;
   logic               flush;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;

   modport master (
      output hw_irq, m_valid, m_pc, m_bd,
      output m_exc_code, m_eret, cp0_req, cp0_epc,
      input  irq_ack, cp0_hwint, cp0_is_exc,
      input  cp0_exc_code, cp0_pc, cp0_isbd,
      input  cp0_exl_clear, flush,
      input  redirect_valid, redirect_pc
   );

   modport slave (
      input  hw_irq, m_valid, m_pc, m_bd,
      input  m_exc_code, m_eret, cp0_req, cp0_epc,
      output irq_ack, cp0_hwint, cp0_is_exc,
      output cp0_exc_code, cp0_pc, cp0_isbd,
      output cp0_exl_clear, flush,
      output redirect_valid, redirect_pc
   );

endinterface

// File: rtl/exc_ctrl_irq_pick.sv
// Lowest-index one-hot picker: isolates the least
// significant set bit of the request vector.
module irq_pick #(
   parameter int N = 6
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   assign gnt = req & (~req + ONE);

endmodule

// File: rtl/exc_ctrl.sv
// Trap/eret sequencer: decides when CP0 takes a trap,
// flushes the pipe, redirects fetch and acks devices.
module exc_ctrl #(
   parameter logic [31:0] HANDLER_PC = exc_ctrl_pkg::HANDLER_PC,
   parameter logic [31:0] RESET_PC   = exc_ctrl_pkg::RESET_PC,
   parameter int          NUM_INT    = 6
) (
   input logic       clk,
   input logic       reset,
   exc_ctrl_if.slave bus
);

   import exc_ctrl_pkg::*;

   logic [1:0]         state;
   logic [1:0]         state_nx;
   logic [31:0]        pc_hold;
   logic               bd_hold;
   logic [31:0]        ret_pc;
   logic [NUM_INT-1:0] hwint_q;
   logic [NUM_INT-1:0] pick;
   logic [NUM_INT-1:0] ack_q;
   logic [4:0]         cause_q;
   logic [4:0]         exc_code;
   logic               is_idle;
   logic               take_trap;
   logic               take_ret;

   logic               flush_c;
   logic               rv_c;
   logic [31:0]        rpc_c;
   logic [NUM_INT-1:0] ack_c;
   logic               exl_c;

   irq_pick #(
      .N (NUM_INT)
   ) u_pick (
      .req (hwint_q),
      .gnt (pick)
   );

   assign exc_code  = bus.m_valid ? bus.m_exc_code : EXC_INT;
   assign is_idle   = (state == ST_IDLE);
   assign take_trap = is_idle & bus.cp0_req;
   assign take_ret  = is_idle & ~bus.cp0_req
                    & bus.m_valid & bus.m_eret;

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: begin
            if (take_trap)
               state_nx = ST_TRAP;
            else if (take_ret)
               state_nx = ST_RET;
         end
         ST_TRAP:  state_nx = ST_GUARD;
         ST_RET:   state_nx = ST_GUARD;
         ST_GUARD: state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= ST_IDLE;
         pc_hold <= RESET_PC;
         bd_hold <= 1'b0;
         ret_pc  <= '0;
         hwint_q <= '0;
         ack_q   <= '0;
         cause_q <= '0;
      end else begin
         state   <= state_nx;
         hwint_q <= bus.hw_irq;
         if (bus.m_valid) begin
            pc_hold <= bus.m_pc;
            bd_hold <= bus.m_bd;
         end
         // Snapshot cause and victim device at the accept edge.
         if (take_trap) begin
            cause_q <= exc_code;
            ack_q   <= pick;
         end
         if (take_ret)
            ret_pc <= bus.cp0_epc;
      end
   end

   always_comb begin
      flush_c = 1'b0;
      rv_c    = 1'b0;
      rpc_c   = '0;
      ack_c   = '0;
      exl_c   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            flush_c = take_trap | take_ret;
            exl_c   = take_ret;
         end
         ST_TRAP: begin
            flush_c = 1'b1;
            rv_c    = 1'b1;
            rpc_c   = HANDLER_PC;
            if (cause_q == EXC_INT)
               ack_c = ack_q;
         end
         ST_RET: begin
            flush_c = 1'b1;
            rv_c    = 1'b1;
            rpc_c   = ret_pc;
         end
         default: ;
      endcase
      // A reset cycle must not leak a redirect or ack.
      if (!reset) begin
         flush_c = 1'b0;
         rv_c    = 1'b0;
         rpc_c   = '0;
         ack_c   = '0;
         exl_c   = 1'b0;
      end
   end

   assign bus.flush          = flush_c;
   assign bus.redirect_valid = rv_c;
   assign bus.redirect_pc    = rpc_c;
   assign bus.irq_ack        = ack_c;
   assign bus.cp0_exl_clear  = exl_c;
   assign bus.cp0_hwint      = hwint_q;
   assign bus.cp0_exc_code   = exc_code;
   assign bus.cp0_pc         = bus.m_valid ? bus.m_pc : pc_hold;
   assign bus.cp0_isbd       = bus.m_valid ? bus.m_bd : bd_hold;
   assign bus.cp0_is_exc     = reset & is_idle & bus.m_valid
                             & (bus.m_exc_code != 5'd0);

endmodule
